// File: rtl/vending_controller_multi.sv
// Multi-product vending controller: product select, coin accumulation, vend handshake,
// greedy change dispensing with inactivity-timeout refund and coin rejection.
module vending_controller_multi #(
    parameter int PROD_W      = 2,
    parameter int CREDIT_W    = 10,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic [PROD_W-1:0]              product,
    input  logic                           product_vld,
    input  logic [(2**PROD_W)*CREDIT_W-1:0] price_tbl,
    input  logic [1:0]                     coin,
    input  logic                           coin_insert,
    input  logic                           coin_return,
    output logic                           coin_reject,
    output logic                           vend_valid,
    output logic [PROD_W-1:0]              vend_product,
    input  logic                           vend_ack,
    output logic                           change_valid,
    output logic [2:0]                     change_coin,
    input  logic                           change_ack,
    output logic [CREDIT_W-1:0]            credit,
    output logic                           busy
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHOOSE = 3'd1,
        S_INSERT = 3'd2,
        S_VEND   = 3'd3,
        S_CHANGE = 3'd4
    } state_t;

    state_t              state_r;
    logic [PROD_W-1:0]   prod_r;
    logic [CREDIT_W-1:0] price_r;
    logic [CREDIT_W-1:0] refund_r;
    logic [TMR_W-1:0]    timer_r;

    logic                timeout_s;
    logic [CREDIT_W:0]   coin_sum_s;
    logic [CREDIT_W-1:0] sel_price_s;
    logic [CREDIT_W-1:0] vend_rem_s;
    logic [CREDIT_W-1:0] change_rem_s;
    logic [2:0]          refund_code_s;
    logic [2:0]          vend_code_s;
    logic [2:0]          next_code_s;

    function automatic logic [CREDIT_W:0] coin_cents(input logic [1:0] c);
        case (c)
            2'b00:   return (CREDIT_W+1)'(5);
            2'b01:   return (CREDIT_W+1)'(10);
            2'b10:   return (CREDIT_W+1)'(25);
            default: return (CREDIT_W+1)'(100);
        endcase
    endfunction

    function automatic logic [CREDIT_W-1:0] change_cents(input logic [2:0] code);
        case (code)
            3'b001:  return CREDIT_W'(5);
            3'b010:  return CREDIT_W'(10);
            3'b011:  return CREDIT_W'(25);
            3'b100:  return CREDIT_W'(100);
            default: return CREDIT_W'(0);
        endcase
    endfunction

    // Largest hopper coin not exceeding the amount; 000 means nothing more can be paid out.
    function automatic logic [2:0] greedy_code(input logic [CREDIT_W-1:0] amt);
        if (amt >= CREDIT_W'(100))     return 3'b100;
        else if (amt >= CREDIT_W'(25)) return 3'b011;
        else if (amt >= CREDIT_W'(10)) return 3'b010;
        else if (amt >= CREDIT_W'(5))  return 3'b001;
        else                           return 3'b000;
    endfunction

    assign timeout_s     = (timer_r == TMR_W'(TIMEOUT_CYC - 1));
    assign coin_sum_s    = {1'b0, credit} + coin_cents(coin);
    assign sel_price_s   = price_tbl[int'(product) * CREDIT_W +: CREDIT_W];
    assign vend_rem_s    = credit - price_r;
    assign change_rem_s  = refund_r - change_cents(change_coin);
    assign refund_code_s = greedy_code(credit);
    assign vend_code_s   = greedy_code(vend_rem_s);
    assign next_code_s   = greedy_code(change_rem_s);

    // Transaction FSM; every output is registered alongside the state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= S_IDLE;
            prod_r       <= '0;
            price_r      <= '0;
            refund_r     <= '0;
            timer_r      <= '0;
            coin_reject  <= 1'b0;
            vend_valid   <= 1'b0;
            vend_product <= '0;
            change_valid <= 1'b0;
            change_coin  <= 3'b000;
            credit       <= '0;
            busy         <= 1'b0;
        end else begin
            coin_reject <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    coin_reject <= coin_insert;
                    credit      <= '0;
                    if (enable) begin
                        state_r <= S_CHOOSE;
                        busy    <= 1'b1;
                        timer_r <= '0;
                    end
                end
                S_CHOOSE: begin
                    coin_reject <= coin_insert;
                    if (coin_return || timeout_s) begin
                        state_r <= S_IDLE;
                        busy    <= 1'b0;
                    end else if (product_vld && product != '0 && sel_price_s != '0) begin
                        prod_r  <= product;
                        price_r <= sel_price_s;
                        timer_r <= '0;
                        state_r <= S_INSERT;
                    end else begin
                        timer_r <= timer_r + TMR_W'(1);
                    end
                end
                S_INSERT: begin
                    if (coin_return || timeout_s) begin
                        coin_reject  <= coin_insert;
                        refund_r     <= credit;
                        change_valid <= (refund_code_s != 3'b000);
                        change_coin  <= refund_code_s;
                        state_r      <= S_CHANGE;
                    end else if (credit >= price_r) begin
                        coin_reject  <= coin_insert;
                        vend_valid   <= 1'b1;
                        vend_product <= prod_r;
                        state_r      <= S_VEND;
                    end else if (coin_insert && !coin_sum_s[CREDIT_W]) begin
                        credit  <= coin_sum_s[CREDIT_W-1:0];
                        timer_r <= '0;
                    end else begin
                        // Overflowing coins are bounced and do not count as activity.
                        coin_reject <= coin_insert;
                        timer_r     <= timer_r + TMR_W'(1);
                    end
                end
                S_VEND: begin
                    coin_reject <= coin_insert;
                    if (vend_ack) begin
                        vend_valid   <= 1'b0;
                        vend_product <= '0;
                        if (vend_rem_s == '0) begin
                            state_r <= S_IDLE;
                            busy    <= 1'b0;
                            credit  <= '0;
                        end else begin
                            refund_r     <= vend_rem_s;
                            change_valid <= (vend_code_s != 3'b000);
                            change_coin  <= vend_code_s;
                            state_r      <= S_CHANGE;
                        end
                    end
                end
                S_CHANGE: begin
                    coin_reject <= coin_insert;
                    if (!change_valid) begin
                        state_r <= S_IDLE;
                        busy    <= 1'b0;
                        credit  <= '0;
                    end else if (change_ack) begin
                        refund_r <= change_rem_s;
                        if (next_code_s != 3'b000) begin
                            change_coin <= next_code_s;
                        end else begin
                            change_valid <= 1'b0;
                            change_coin  <= 3'b000;
                            state_r      <= S_IDLE;
                            busy         <= 1'b0;
                            credit       <= '0;
                        end
                    end
                end
                default: begin
                    state_r      <= S_IDLE;
                    vend_valid   <= 1'b0;
                    vend_product <= '0;
                    change_valid <= 1'b0;
                    change_coin  <= 3'b000;
                    credit       <= '0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vending_controller_multi.sv
// Self-checking bench for vending_controller_multi: vector table, directed corner cases,
// and randomized traffic compared against a transaction-level reference model.
module tb_vending_controller_multi;

    localparam int PROD_W   = 2;
    localparam int CREDIT_W = 10;
    localparam int TMO      = 16;
    localparam int CMAX     = 1023;
    localparam int M_OFF = 0, M_PICK = 1, M_PAY = 2, M_DISP = 3, M_GIVE = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, enable, product_vld, coin_insert, coin_return, vend_ack, change_ack;
    logic [1:0]  product, coin;
    logic [4*CREDIT_W-1:0] price_tbl;
    logic        coin_reject, vend_valid, change_valid, busy;
    logic [1:0]  vend_product;
    logic [2:0]  change_coin;
    logic [CREDIT_W-1:0] credit;

    vending_controller_multi #(.PROD_W(PROD_W), .CREDIT_W(CREDIT_W), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .product(product),
        .product_vld(product_vld), .price_tbl(price_tbl), .coin(coin),
        .coin_insert(coin_insert), .coin_return(coin_return), .coin_reject(coin_reject),
        .vend_valid(vend_valid), .vend_product(vend_product), .vend_ack(vend_ack),
        .change_valid(change_valid), .change_coin(change_coin), .change_ack(change_ack),
        .credit(credit), .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int prices[4];

    // Reference model: transaction phase, money held, and the list of change coins still owed.
    int m_mode, m_credit, m_price, m_prod, m_idle, m_rej;
    int m_q[$];
    int denoms[4] = '{100, 25, 10, 5};

    bit auto_ack;
    int ack_delay, vcnt, ccnt;
    int obs_vend;
    int obs_chg[$];

    typedef struct {
        logic [1:0] prod;
        logic [1:0] coin;
        int         n;
        bit         ret;
        int         vend;
        int         nchg;
        int         chg[2];
    } vec_t;
    vec_t vecs[8];

    function automatic int cents(input logic [1:0] c);
        case (c)
            2'b00:   return 5;
            2'b01:   return 10;
            2'b10:   return 25;
            default: return 100;
        endcase
    endfunction

    function automatic int code_of(input int v);
        case (v)
            100:     return 4;
            25:      return 3;
            10:      return 2;
            5:       return 1;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_prices(input int p0, input int p1, input int p2, input int p3);
        prices[0] = p0; prices[1] = p1; prices[2] = p2; prices[3] = p3;
        price_tbl = {10'(p3), 10'(p2), 10'(p1), 10'(p0)};
    endtask

    task automatic start_change(input int amt);
        int r = amt;
        m_q.delete();
        foreach (denoms[i]) begin
            while (r >= denoms[i]) begin
                m_q.push_back(denoms[i]);
                r -= denoms[i];
            end
        end
        m_mode = M_GIVE;
    endtask

    task automatic finish_txn();
        m_mode   = M_OFF;
        m_credit = 0;
    endtask

    task automatic model_step();
        m_rej = 0;
        if (!reset_n) begin
            finish_txn();
            m_q.delete();
            return;
        end
        case (m_mode)
            M_OFF: begin
                m_rej = coin_insert; m_credit = 0;
                if (enable) begin m_mode = M_PICK; m_idle = 0; end
            end
            M_PICK: begin
                m_rej = coin_insert;
                if (coin_return || m_idle + 1 == TMO) m_mode = M_OFF;
                else if (product_vld && product != 0 && prices[product] != 0) begin
                    m_prod = product; m_price = prices[product]; m_idle = 0; m_mode = M_PAY;
                end else m_idle++;
            end
            M_PAY: begin
                if (coin_return || m_idle + 1 == TMO) begin
                    m_rej = coin_insert; start_change(m_credit);
                end else if (m_credit >= m_price) begin
                    m_rej = coin_insert; m_mode = M_DISP;
                end else if (coin_insert && m_credit + cents(coin) <= CMAX) begin
                    m_credit += cents(coin); m_idle = 0;
                end else begin
                    m_rej = coin_insert; m_idle++;
                end
            end
            M_DISP: begin
                m_rej = coin_insert;
                if (vend_ack) begin
                    if (m_credit == m_price) finish_txn();
                    else start_change(m_credit - m_price);
                end
            end
            default: begin
                m_rej = coin_insert;
                if (m_q.size() == 0) finish_txn();
                else if (change_ack) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) finish_txn();
                end
            end
        endcase
    endtask

    task automatic tick();
        int e_cv;
        if (reset_n) begin
            if (vend_valid && vend_ack) obs_vend = vend_product;
            if (change_valid && change_ack) obs_chg.push_back(int'(change_coin));
        end
        model_step();
        @(posedge clk);
        #1;
        e_cv = (m_mode == M_GIVE && m_q.size() > 0) ? 1 : 0;
        check("coin_reject", int'(coin_reject), m_rej);
        check("vend_valid", int'(vend_valid), (m_mode == M_DISP) ? 1 : 0);
        check("vend_product", int'(vend_product), (m_mode == M_DISP) ? m_prod : 0);
        check("change_valid", int'(change_valid), e_cv);
        check("change_coin", int'(change_coin), e_cv ? code_of(m_q[0]) : 0);
        check("credit", int'(credit), m_credit);
        check("busy", int'(busy), (m_mode != M_OFF) ? 1 : 0);
        if (auto_ack) begin
            if (vend_ack) vcnt = 0;
            vcnt = vend_valid ? vcnt + 1 : 0;
            vend_ack = vend_valid && (vcnt > ack_delay);
            if (change_ack) ccnt = 0;
            ccnt = change_valid ? ccnt + 1 : 0;
            change_ack = change_valid && (ccnt > ack_delay);
        end
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin tick(); k++; end
        check("idle_within_budget", int'(busy), 0);
    endtask

    task automatic begin_txn(input logic [1:0] prod);
        obs_vend = 0;
        obs_chg.delete();
        enable = 1'b1; tick(); enable = 1'b0;
        product = prod; product_vld = 1'b1; tick(); product_vld = 1'b0;
    endtask

    task automatic put_coin(input logic [1:0] c);
        coin = c; coin_insert = 1'b1; tick(); coin_insert = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        begin_txn(v.prod);
        for (int i = 0; i < v.n; i++) put_coin(v.coin);
        if (v.ret) begin coin_return = 1'b1; tick(); coin_return = 1'b0; end
        wait_idle(100);
        check("vec_vend", obs_vend, v.vend);
        check("vec_nchg", obs_chg.size(), v.nchg);
        for (int k = 0; k < v.nchg && k < obs_chg.size(); k++) check("vec_chg", obs_chg[k], v.chg[k]);
    endtask

    initial begin
        vecs[0] = '{2'd1, 2'b10, 3, 1'b0, 1, 1, '{2, 0}};
        vecs[1] = '{2'd3, 2'b11, 2, 1'b0, 3, 2, '{3, 3}};
        vecs[2] = '{2'd2, 2'b01, 1, 1'b1, 0, 1, '{2, 0}};
        vecs[3] = '{2'd2, 2'b11, 1, 1'b0, 2, 0, '{0, 0}};
        vecs[4] = '{2'd1, 2'b00, 1, 1'b1, 0, 1, '{1, 0}};
        vecs[5] = '{2'd1, 2'b11, 1, 1'b0, 1, 2, '{3, 2}};
        vecs[6] = '{2'd1, 2'b01, 7, 1'b0, 1, 1, '{1, 0}};
        vecs[7] = '{2'd3, 2'b10, 5, 1'b1, 0, 2, '{4, 3}};

        reset_n = 1'b0; enable = 1'b0; product = 2'd0; product_vld = 1'b0; coin = 2'b00;
        coin_insert = 1'b0; coin_return = 1'b0; vend_ack = 1'b0; change_ack = 1'b0;
        auto_ack = 1'b1; ack_delay = 1; vcnt = 0; ccnt = 0;
        m_mode = M_OFF; m_credit = 0; m_price = 0; m_prod = 0; m_idle = 0; m_rej = 0;
        set_prices(40, 65, 100, 150);
        tick(); tick();
        check("reset_busy", int'(busy), 0);
        check("reset_credit", int'(credit), 0);
        reset_n = 1'b1;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Coin arriving together with coin_return is bounced; only the held 25c comes back.
        begin_txn(2'd2);
        put_coin(2'b10);
        coin = 2'b10; coin_insert = 1'b1; coin_return = 1'b1; tick();
        coin_insert = 1'b0; coin_return = 1'b0;
        check("same_cycle_reject", int'(coin_reject), 1);
        wait_idle(50);
        check("same_cycle_nchg", obs_chg.size(), 1);
        if (obs_chg.size() > 0) check("same_cycle_chg", obs_chg[0], 3);

        // Inactivity timeout refund, then change held while the hopper stalls.
        auto_ack = 1'b0;
        begin_txn(2'd1);
        put_coin(2'b00);
        for (int i = 0; i < TMO - 1; i++) tick();
        check("tmo_not_yet", int'(change_valid), 0);
        tick();
        check("tmo_valid", int'(change_valid), 1);
        check("tmo_coin", int'(change_coin), 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("tmo_hold_coin", int'(change_coin), 1);
        end
        auto_ack = 1'b1; ccnt = 0; vcnt = 0;
        wait_idle(50);
        check("tmo_nchg", obs_chg.size(), 1);

        // Reset while change is pending, then a normal transaction.
        ack_delay = 5;
        begin_txn(2'd3);
        put_coin(2'b11); put_coin(2'b11);
        for (int i = 0; i < 30 && !change_valid; i++) tick();
        check("pre_reset_change_valid", int'(change_valid), 1);
        reset_n = 1'b0; tick();
        check("rst_change_valid", int'(change_valid), 0);
        check("rst_change_coin", int'(change_coin), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_credit", int'(credit), 0);
        reset_n = 1'b1; ack_delay = 1; vend_ack = 1'b0; change_ack = 1'b0;
        run_vec(vecs[0]);

        // Zero-price and code-0 selections are ignored; a coin in CHOOSE is bounced.
        set_prices(40, 65, 100, 0);
        begin_txn(2'd3);
        product = 2'd0; product_vld = 1'b1; tick(); product_vld = 1'b0;
        put_coin(2'b11);
        check("choose_reject", int'(coin_reject), 1);
        check("choose_credit", int'(credit), 0);
        coin_return = 1'b1; tick(); coin_return = 1'b0;
        wait_idle(20);

        // Credit saturation: a coin that would overflow the counter is rejected.
        set_prices(40, 65, 100, 1023);
        begin_txn(2'd3);
        for (int i = 0; i < 10; i++) put_coin(2'b11);
        put_coin(2'b10);
        check("ovf_reject", int'(coin_reject), 1);
        check("ovf_credit", int'(credit), 1000);
        coin_return = 1'b1; tick(); coin_return = 1'b0;
        wait_idle(200);
        check("ovf_nchg", obs_chg.size(), 10);

        // Randomized traffic against the reference model.
        set_prices($urandom_range(0, 300), $urandom_range(1, 300), $urandom_range(0, 300),
                   $urandom_range(1, 300));
        auto_ack = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            reset_n     = ($urandom_range(0, 299) != 0);
            enable      = ($urandom_range(0, 3) == 0);
            product     = 2'($urandom_range(0, 3));
            product_vld = ($urandom_range(0, 2) == 0);
            coin        = 2'($urandom_range(0, 3));
            coin_insert = ($urandom_range(0, 1) == 0);
            coin_return = ($urandom_range(0, 39) == 0);
            vend_ack    = ($urandom_range(0, 2) == 0);
            change_ack  = ($urandom_range(0, 1) == 0);
            tick();
        end
        reset_n = 1'b1; enable = 1'b0; product_vld = 1'b0; coin_insert = 1'b0;
        coin_return = 1'b0; vend_ack = 1'b1; change_ack = 1'b1;
        wait_idle(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
